sr_latch_driver: RTL and testbench



---
 rtl/sr_latch_driver_pkg.sv | 23 ++
 rtl/sr_latch_driver_if.sv | 12 +
 rtl/sr_latch_driver_pulse_timer.sv | 27 ++
 rtl/sr_latch_driver.sv | 151 +++++++++++++++
 tb/tb_sr_latch_driver.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/sr_latch_driver_pkg.sv
// Shared types and elaboration helpers for the SR latch write driver.
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP,
    CHECK
  } sr_state_e;

  localparam int N_LATCH_MIN      = 2;
  localparam int N_LATCH_MAX      = 256;
  localparam int PULSE_CYCLES_MIN = 1;
  localparam int GAP_CYCLES_MIN   = 0;

  // The timer holds at most max(P, G) - 1, so this is the bit width needed.
  function automatic int max_w(input int pulse_cycles, input int gap_cycles);
    int m;
    m = (pulse_cycles > gap_cycles) ? pulse_cycles : gap_cycles;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sr_latch_driver_if.sv
// Write-request handshake between a requester and sr_latch_driver.
interface sr_latch_driver_if #(
  parameter int AW = 3
);
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_data;

  modport master (output req_valid, output req_addr, output req_data, input req_ready);
  modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface

// File: rtl/sr_latch_driver_pulse_timer.sv
// Loadable down-counter with zero flag, shared by the pulse and gap phases.
module sr_pulse_timer #(
  parameter int CW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] load_val,
  output logic          zero
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// Write-side controller for a bank of SR latches: one-hot S/R pulse, dead time, readback.
// Optional SR_SHADOW_SKIP_EN: skip the pulse when a verified shadow copy already matches.
module sr_latch_driver
  import sr_pkg::*;
#(
  parameter int N_LATCH      = 8,
  parameter int AW           = $clog2(N_LATCH),
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 1
) (
  input  logic               clk,
  input  logic               rst,
  sr_latch_driver_if.slave   req,
  output logic [N_LATCH-1:0] s_out,
  output logic [N_LATCH-1:0] r_out,
  input  logic [N_LATCH-1:0] q_in,
  output logic               busy,
  output logic               done,
  output logic               err
);

  if (N_LATCH < N_LATCH_MIN || N_LATCH > N_LATCH_MAX) begin : g_bad_n_latch
    $error("sr_latch_driver: N_LATCH out of range");
  end
  if (PULSE_CYCLES < PULSE_CYCLES_MIN || GAP_CYCLES < GAP_CYCLES_MIN) begin : g_bad_timing
    $error("sr_latch_driver: PULSE_CYCLES/GAP_CYCLES out of range");
  end
  if (AW < $clog2(N_LATCH)) begin : g_bad_aw
    $error("sr_latch_driver: AW too narrow for N_LATCH");
  end

  localparam int                 CW         = max_w(PULSE_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0]      PULSE_LOAD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0]      GAP_LOAD   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [N_LATCH-1:0] ONE        = N_LATCH'(1);

  sr_state_e     state, state_nx;
  logic [AW-1:0] addr_q;
  logic          data_q;
  logic          bad_q;

  logic               accept, req_bad, req_skip;
  logic               t_load, t_dec, t_zero;
  logic [CW-1:0]      t_load_val;
  logic [N_LATCH-1:0] sel;
  logic               q_rd;

  assign req.req_ready = (state == IDLE);
  assign accept        = req.req_valid & req.req_ready;
  assign req_bad       = (32'(req.req_addr) >= N_LATCH);

  // Shifting by an out-of-range address yields all zeros, so bad writes select nothing.
  assign sel  = ONE << addr_q;
  assign q_rd = |(q_in & sel);

  assign busy = (state != IDLE);
  assign done = (state == CHECK);
  assign err  = done & (bad_q | (q_rd != data_q));

  sr_pulse_timer #(
    .CW(CW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (t_load),
    .dec     (t_dec),
    .load_val(t_load_val),
    .zero    (t_zero)
  );

`ifdef SR_SHADOW_SKIP_EN
  logic [N_LATCH-1:0] shadow_val, shadow_ok, req_sel;

  assign req_sel  = ONE << req.req_addr;
  assign req_skip = |(req_sel & shadow_ok & ~(shadow_val ^ {N_LATCH{req.req_data}}));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_val <= '0;
      shadow_ok  <= '0;
    end else if (state == CHECK) begin
      if (err) begin
        shadow_ok <= shadow_ok & ~sel;
      end else begin
        shadow_ok  <= shadow_ok | sel;
        shadow_val <= data_q ? (shadow_val | sel) : (shadow_val & ~sel);
      end
    end
  end
`else
  assign req_skip = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      addr_q <= '0;
      data_q <= 1'b0;
      bad_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        addr_q <= req.req_addr;
        data_q <= req.req_data;
        bad_q  <= req_bad;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    t_load     = 1'b0;
    t_dec      = 1'b0;
    t_load_val = PULSE_LOAD;
    s_out      = '0;
    r_out      = '0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (req_bad || req_skip) begin
            state_nx = CHECK;
          end else begin
            state_nx = PULSE;
            t_load   = 1'b1;
          end
        end
      end
      PULSE: begin
        s_out = data_q ? sel : '0;
        r_out = data_q ? '0 : sel;
        t_dec = 1'b1;
        if (t_zero) begin
          if (GAP_CYCLES == 0) begin
            state_nx = CHECK;
          end else begin
            state_nx   = GAP;
            t_load     = 1'b1;
            t_load_val = GAP_LOAD;
          end
        end
      end
      GAP: begin
        t_dec = 1'b1;
        if (t_zero) state_nx = CHECK;
      end
      CHECK:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Randomized bench for sr_latch_driver against a transaction-level latch/shadow model.
module tb_sr_latch_driver;

  localparam int N  = 8;
  localparam int AW = 4;
  localparam int P  = 2;
  localparam int G  = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] s_out, r_out, q_in;
  logic [N-1:0] lq    = '0;
  logic [N-1:0] stuck = '0;
  logic         busy, done, err;

  int n_checks = 0;
  int n_errors = 0;

  bit exp_q  [N];
  bit sh_ok  [N];
  bit sh_val [N];

  sr_latch_driver_if #(.AW(AW)) bus ();

  sr_latch_driver #(
    .N_LATCH     (N),
    .AW          (AW),
    .PULSE_CYCLES(P),
    .GAP_CYCLES  (G)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (bus.slave),
    .s_out(s_out),
    .r_out(r_out),
    .q_in (q_in),
    .busy (busy),
    .done (done),
    .err  (err)
  );

  always #5 clk = ~clk;

  // Physical latch: set/reset as soon as a line rises; a stuck latch always reads 0.
  always @(s_out or r_out) begin
    for (int i = 0; i < N; i++) begin
      if (s_out[i]) lq[i] = 1'b1;
      else if (r_out[i]) lq[i] = 1'b0;
    end
  end
  assign q_in = lq & ~stuck;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_invariants();
    check_eq("s_and_r_zero", 32'(s_out & r_out), 32'd0);
    check_eq("at_most_one_line", 32'($countones(s_out | r_out) <= 1), 32'd1);
  endtask

  task automatic clear_shadow_model();
    for (int i = 0; i < N; i++) sh_ok[i] = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the following idle cycle.
  task automatic txn(input logic [AW-1:0] a, input logic d, input bit hold,
                     input logic [AW-1:0] na, input logic nd);
    int           ai;
    bit           bad, skip, exp_err;
    int           len;
    logic [N-1:0] pat, exp_s, exp_r;
    ai = int'(a);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_data  = d;
    check_eq("idle_ready", 32'(bus.req_ready), 32'd1);
    check_eq("idle_busy", 32'(busy), 32'd0);
    bad  = (ai >= N);
    skip = 1'b0;
`ifdef SR_SHADOW_SKIP_EN
    if (!bad) skip = sh_ok[ai] && (sh_val[ai] == d);
`endif
    len = (bad || skip) ? 1 : P + G + 1;
    pat = '0;
    if (!bad) pat[ai] = 1'b1;
    if (!bad && !skip) exp_q[ai] = stuck[ai] ? 1'b0 : d;
    exp_err = bad ? 1'b1 : (exp_q[ai] != d);
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      exp_s = (!bad && !skip && k <= P && d)  ? pat : '0;
      exp_r = (!bad && !skip && k <= P && !d) ? pat : '0;
      check_eq("s_out", 32'(s_out), 32'(exp_s));
      check_eq("r_out", 32'(r_out), 32'(exp_r));
      check_eq("busy", 32'(busy), 32'd1);
      check_eq("ready_busy", 32'(bus.req_ready), 32'd0);
      check_eq("done", 32'(done), 32'(k == len));
      check_eq("err", 32'(err), 32'(k == len && exp_err));
      check_invariants();
      if (k == 1 && !hold) bus.req_valid = 1'b0;
      if (k == len) begin
        if (!bad) begin
          check_eq("q_readback", 32'(q_in[ai]), 32'(exp_q[ai]));
          if (exp_err) sh_ok[ai] = 1'b0;
          else begin
            sh_ok[ai]  = 1'b1;
            sh_val[ai] = d;
          end
        end
        if (hold) begin
          bus.req_addr = na;
          bus.req_data = nd;
        end
      end
    end
    @(negedge clk);
    check_eq("after_ready", 32'(bus.req_ready), 32'd1);
    check_eq("after_busy", 32'(busy), 32'd0);
    check_eq("after_done", 32'(done), 32'd0);
    check_eq("after_lines", 32'(s_out | r_out), 32'd0);
  endtask

  initial begin
    logic [AW-1:0] a, na;
    logic          d, nd;
    bit            hold;

    for (int i = 0; i < N; i++) begin
      exp_q[i]  = 1'b0;
      sh_val[i] = 1'b0;
    end
    clear_shadow_model();

    // Reset with a request presented: it must be ignored.
    rst           = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 4'd3;
    bus.req_data  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_s_out", 32'(s_out), 32'd0);
      check_eq("rst_r_out", 32'(r_out), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_err", 32'(err), 32'd0);
      check_eq("rst_ready", 32'(bus.req_ready), 32'd1);
    end
    bus.req_valid = 1'b0;
    rst           = 1'b0;
    @(negedge clk);
    check_eq("post_rst_busy", 32'(busy), 32'd0);

    txn(4'd3, 1'b1, 1'b0, 4'd0, 1'b0);
    txn(4'd3, 1'b0, 1'b0, 4'd0, 1'b0);
    stuck[5] = 1'b1;
    txn(4'd5, 1'b1, 1'b0, 4'd0, 1'b0);
    txn(4'd9, 1'b1, 1'b0, 4'd0, 1'b0);
    txn(4'd0, 1'b1, 1'b1, 4'd1, 1'b1);
    txn(4'd1, 1'b1, 1'b0, 4'd0, 1'b0);
    txn(4'd2, 1'b1, 1'b0, 4'd0, 1'b0);
    txn(4'd2, 1'b1, 1'b0, 4'd0, 1'b0);

    // Reset in the first pulse cycle: lines drop without a clock edge, no done.
    bus.req_valid = 1'b1;
    bus.req_addr  = 4'd4;
    bus.req_data  = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check_eq("mid_s_out", 32'(s_out), 32'h10);
    #2 rst = 1'b1;
    #1;
    check_eq("async_s_out", 32'(s_out), 32'd0);
    check_eq("async_r_out", 32'(r_out), 32'd0);
    check_eq("async_busy", 32'(busy), 32'd0);
    check_eq("async_done", 32'(done), 32'd0);
    clear_shadow_model();
    exp_q[4] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_hold_done", 32'(done), 32'd0);
    end
    rst = 1'b0;
    repeat (P + G + 1) begin
      @(negedge clk);
      check_eq("post_abort_done", 32'(done), 32'd0);
      check_eq("post_abort_busy", 32'(busy), 32'd0);
    end
    check_eq("latch4_kept", 32'(q_in[4]), 32'd1);

    a = 4'(($urandom_range(0, 11)));
    d = 1'($urandom_range(0, 1));
    for (int t = 0; t < 40; t++) begin
      na   = 4'($urandom_range(0, 11));
      nd   = 1'($urandom_range(0, 1));
      hold = 1'($urandom_range(0, 1));
      txn(a, d, hold, na, nd);
      a = na;
      d = nd;
    end
    bus.req_valid = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
